// File: rtl/piece_sequencer.sv
// piece_sequencer: per-player tetromino sequencer with preview queue, hold slot,
// dealt-piece counter and create/created spawn handshake.
module piece_sequencer #(
    parameter int NUM_PLAYERS   = 2,
    parameter int PREVIEW_DEPTH = 3,
    parameter int PIECE_W       = 3
) (
    input  logic                                       Clk,
    input  logic                                       Reset,
    input  logic                                       start,
    input  logic [NUM_PLAYERS-1:0]                     active_mask,
    input  logic [NUM_PLAYERS*PIECE_W-1:0]             rand_piece,
    input  logic [NUM_PLAYERS-1:0]                     finish_block,
    input  logic [NUM_PLAYERS-1:0]                     created,
    input  logic [NUM_PLAYERS-1:0]                     hold_req,
    input  logic [NUM_PLAYERS-1:0]                     game_over,
    output logic [NUM_PLAYERS*PIECE_W-1:0]             curr_piece,
    output logic [NUM_PLAYERS*PREVIEW_DEPTH*PIECE_W-1:0] next_pieces,
    output logic [NUM_PLAYERS*PIECE_W-1:0]             hold_piece,
    output logic [NUM_PLAYERS-1:0]                     hold_valid,
    output logic [NUM_PLAYERS-1:0]                     create_block,
    output logic [NUM_PLAYERS-1:0]                     piece_swap,
    output logic [NUM_PLAYERS*16-1:0]                  pieces_dealt
);
    typedef enum logic [2:0] {IDLE, FILL, SPAWN, PLAY, OVER} state_t;

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_p
        state_t             state_q;
        logic [PIECE_W-1:0] curr_q, hold_q, rnd_raw, rnd;
        logic [PIECE_W-1:0] que_q [PREVIEW_DEPTH];
        logic               hold_valid_q, hold_used_q, swap_q;
        logic [2:0]         fill_q;
        logic [15:0]        dealt_q;
        logic               ov, go, fill, fin, hacc, push, inc;

        assign rnd_raw = rand_piece[p*PIECE_W +: PIECE_W];
        assign rnd     = (rnd_raw == PIECE_W'(7)) ? '0 : rnd_raw;

        // game_over outranks every other event once the player has left IDLE
        always_comb begin
            ov   = game_over[p] && state_q != IDLE;
            go   = start && (state_q == IDLE || state_q == OVER) && !ov;
            fill = state_q == FILL && !ov;
            fin  = state_q == PLAY && finish_block[p] && !ov;
            hacc = state_q == PLAY && hold_req[p] && !hold_used_q && !finish_block[p] && !ov;
            push = fill || fin || (hacc && !hold_valid_q);
            inc  = (fill && fill_q == 3'(PREVIEW_DEPTH)) || fin || (hacc && !hold_valid_q);
        end

        always_ff @(posedge Clk) begin
            if (Reset) begin
                state_q      <= IDLE;
                curr_q       <= '0;
                hold_q       <= '0;
                hold_valid_q <= 1'b0;
                hold_used_q  <= 1'b0;
                swap_q       <= 1'b0;
                fill_q       <= '0;
                dealt_q      <= '0;
                for (int i = 0; i < PREVIEW_DEPTH; i++) que_q[i] <= '0;
            end else begin
                swap_q <= 1'b0;
                if (ov) begin
                    state_q <= OVER;
                end else if (go) begin
                    state_q      <= active_mask[p] ? FILL : IDLE;
                    if (active_mask[p]) begin
                        fill_q       <= '0;
                        hold_q       <= '0;
                        hold_valid_q <= 1'b0;
                        hold_used_q  <= 1'b0;
                        dealt_q      <= '0;
                    end
                end else if (fill) begin
                    fill_q  <= fill_q + 3'd1;
                    state_q <= (fill_q == 3'(PREVIEW_DEPTH)) ? SPAWN : FILL;
                end else if (state_q == SPAWN && created[p]) begin
                    state_q <= PLAY;
                end else if (fin) begin
                    hold_used_q <= 1'b0;
                    state_q     <= SPAWN;
                end else if (hacc) begin
                    hold_used_q  <= 1'b1;
                    swap_q       <= 1'b1;
                    state_q      <= SPAWN;
                    hold_q       <= curr_q;
                    hold_valid_q <= 1'b1;
                    if (hold_valid_q) curr_q <= hold_q;
                end
                if (push) begin
                    curr_q <= que_q[0];
                    for (int i = 0; i < PREVIEW_DEPTH - 1; i++) que_q[i] <= que_q[i+1];
                    que_q[PREVIEW_DEPTH-1] <= rnd;
                end
                if (inc && dealt_q != 16'hFFFF) dealt_q <= dealt_q + 16'd1;
            end
        end

        assign curr_piece[p*PIECE_W +: PIECE_W]  = curr_q;
        assign hold_piece[p*PIECE_W +: PIECE_W]  = hold_q;
        assign hold_valid[p]                     = hold_valid_q;
        assign create_block[p]                   = state_q == SPAWN;
        assign piece_swap[p]                     = swap_q;
        assign pieces_dealt[p*16 +: 16]          = dealt_q;
        for (genvar i = 0; i < PREVIEW_DEPTH; i++) begin : g_i
            assign next_pieces[(p*PREVIEW_DEPTH+i)*PIECE_W +: PIECE_W] = que_q[i];
        end
    end
endmodule

// File: tb/tb_piece_sequencer.sv
// tb_piece_sequencer: directed checks of fill, spawn handshake, hold/swap,
// sanitising, game over isolation and reset recovery.
module tb_piece_sequencer;
    logic        Clk = 0, Reset = 1, start = 0;
    logic [1:0]  active_mask = 0, finish_block = 0, created = 0, hold_req = 0, game_over = 0;
    logic [5:0]  rand_piece = 0;
    logic [5:0]  curr_piece, hold_piece;
    logic [17:0] next_pieces;
    logic [1:0]  hold_valid, create_block, piece_swap;
    logic [31:0] pieces_dealt;
    int checks = 0, failures = 0;

    piece_sequencer #(.NUM_PLAYERS(2), .PREVIEW_DEPTH(3), .PIECE_W(3)) dut (
        .Clk(Clk), .Reset(Reset), .start(start), .active_mask(active_mask),
        .rand_piece(rand_piece), .finish_block(finish_block), .created(created),
        .hold_req(hold_req), .game_over(game_over), .curr_piece(curr_piece),
        .next_pieces(next_pieces), .hold_piece(hold_piece), .hold_valid(hold_valid),
        .create_block(create_block), .piece_swap(piece_swap), .pieces_dealt(pieces_dealt)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    function automatic logic [2:0] cur(int p);
        return curr_piece[p*3 +: 3];
    endfunction

    function automatic logic [2:0] nxt(int p, int i);
        return next_pieces[(p*3+i)*3 +: 3];
    endfunction

    function automatic logic [2:0] hld(int p);
        return hold_piece[p*3 +: 3];
    endfunction

    function automatic logic [15:0] dealt(int p);
        return pieces_dealt[p*16 +: 16];
    endfunction

    task automatic fill0(input logic [2:0] a, b, c, d);
        logic [2:0] v [4];
        v = '{a, b, c, d};
        for (int k = 0; k < 4; k++) begin
            rand_piece[2:0] = v[k];
            step();
        end
    endtask

    initial begin
        step(); step();
        Reset = 0;
        check("rst_curr", curr_piece, 0);
        check("rst_next", next_pieces, 0);
        check("rst_create", create_block, 0);
        check("rst_dealt", pieces_dealt, 0);
        check("rst_hold", {hold_valid, hold_piece, piece_swap}, 0);

        start = 1; active_mask = 2'b01; step(); start = 0;
        rand_piece[2:0] = 1; step();
        rand_piece[2:0] = 2; step();
        rand_piece[2:0] = 3; step();
        check("fill_no_create_yet", create_block, 0);
        rand_piece[2:0] = 4; step();
        check("fill_curr", cur(0), 1);
        check("fill_next", {nxt(0,0), nxt(0,1), nxt(0,2)}, {3'd2, 3'd3, 3'd4});
        check("fill_create", create_block, 2'b01);
        check("fill_dealt", dealt(0), 1);
        check("p1_idle", {cur(1), nxt(1,0), nxt(1,1), nxt(1,2), dealt(1), hold_valid[1], piece_swap[1]}, 0);

        created = 2'b01; step(); created = 0;
        check("created_drop", create_block, 0);
        finish_block = 2'b01; rand_piece[2:0] = 5; step(); finish_block = 0;
        check("fin_curr", cur(0), 2);
        check("fin_next", {nxt(0,0), nxt(0,1), nxt(0,2)}, {3'd3, 3'd4, 3'd5});
        check("fin_create", create_block, 2'b01);
        check("fin_dealt", dealt(0), 2);

        created = 2'b01; step(); created = 0;
        hold_req = 2'b01; rand_piece[2:0] = 6; step(); hold_req = 0;
        check("hold1_slot", {hold_valid[0], hld(0)}, {1'b1, 3'd2});
        check("hold1_curr", cur(0), 3);
        check("hold1_swap", piece_swap, 2'b01);
        check("hold1_create", create_block, 2'b01);
        check("hold1_dealt", dealt(0), 3);
        step();
        check("swap_one_cycle", piece_swap, 0);
        created = 2'b01; step(); created = 0;
        hold_req = 2'b01; step(); hold_req = 0;
        check("hold2_ignored", {create_block, piece_swap, cur(0), hld(0)}, {2'b00, 2'b00, 3'd3, 3'd2});

        finish_block = 2'b01; rand_piece[2:0] = 7; step(); finish_block = 0;
        check("sanitize_tail", {nxt(0,0), nxt(0,1), nxt(0,2)}, {3'd5, 3'd6, 3'd0});
        check("fin2_curr", cur(0), 4);
        created = 2'b01; step(); created = 0;
        hold_req = 2'b01; step(); hold_req = 0;
        check("hold3_swap", {cur(0), hld(0), hold_valid[0]}, {3'd2, 3'd4, 1'b1});
        check("hold3_dealt", dealt(0), 4);
        check("hold3_pulse", {piece_swap, create_block}, {2'b01, 2'b01});

        Reset = 1; step(); Reset = 0;
        start = 1; active_mask = 2'b11; step(); start = 0;
        for (int k = 0; k < 4; k++) begin
            rand_piece = {3'(6 - k), 3'(k + 1)};
            step();
        end
        check("two_create", create_block, 2'b11);
        check("p1_fill", {cur(1), nxt(1,0), nxt(1,1), nxt(1,2)}, {3'd6, 3'd5, 3'd4, 3'd3});
        game_over = 2'b10; step(); game_over = 0;
        check("over_create", create_block, 2'b01);
        check("over_freeze", {cur(1), dealt(1)}, {3'd6, 16'd1});
        created = 2'b11; step(); created = 0;
        finish_block = 2'b01; hold_req = 2'b01; rand_piece = 6'o05; step();
        finish_block = 0; hold_req = 0;
        check("finhold_curr", cur(0), 2);
        check("finhold_hold", {hold_valid, piece_swap}, 0);
        check("finhold_create", create_block, 2'b01);
        check("finhold_dealt", dealt(0), 2);
        check("over_ignores_created", {create_block[1], cur(1)}, {1'b0, 3'd6});

        Reset = 1; step(); Reset = 0;
        check("rst_spawn", {create_block, curr_piece, next_pieces, pieces_dealt}, 0);
        start = 1; active_mask = 2'b01; step(); start = 0;
        rand_piece[2:0] = 1; step();
        rand_piece[2:0] = 2; step();
        Reset = 1; step(); Reset = 0;
        check("rst_fill", {create_block, curr_piece, next_pieces, pieces_dealt}, 0);
        start = 1; step(); start = 0;
        fill0(3, 4, 5, 6);
        check("refill_curr", cur(0), 3);
        check("refill_next", {nxt(0,0), nxt(0,1), nxt(0,2)}, {3'd4, 3'd5, 3'd6});
        check("refill_create_dealt", {create_block, dealt(0)}, {2'b01, 16'd1});
        start = 1; step(); start = 0;
        check("start_in_spawn_ignored", {create_block, cur(0)}, {2'b01, 3'd3});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
